mdu_iter: RTL and testbench

Iterative 32-bit multiply/divide unit for the CPU datapath. Executes MULT, MULTU, DIV and DIVU over a fixed multi-cycle sequence and holds the 64-bit result in HI/LO. The LO value feeds the result mux ahead of the 32-bit zero detector, so the downstream zero flag is valid for mul/div results. The pipeline stalls on `busy`.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_step.sv | 42 ++++
 rtl/mdu_iter.sv | 133 +++++++++++++
 tb/tb_mdu_iter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcode/state encodings and the iteration count for the
// iterative multiply/divide unit.
// Contents: op_e (MULTU/MULT/DIVU/DIV), state_e (IDLE/CALC/FIX), MDU_ITERS.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  localparam int MDU_ITERS = 32;

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one iteration of the shift-add multiply or the restoring
// shift-subtract divide, purely combinational, no backpressure.
// Ports: div (1 = divide step), acc (2*WIDTH accumulator), m (multiplicand
//        or divisor magnitude), acc_next (accumulator after this step).
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH-1:0] acc_next
);

  // Multiply: acc = {partial product, remaining multiplier bits}. Add the
  // multiplicand into the upper half when the current multiplier bit is set,
  // then shift the whole thing right, keeping the carry out of the add.
  logic [WIDTH:0] mul_sum;

  // Divide: acc = {partial remainder, remaining dividend bits}. Shift left
  // one bit into a WIDTH+1 trial remainder and subtract if it fits.
  logic [WIDTH:0] div_rem;
  logic [WIDTH:0] div_diff;
  logic           div_fits;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    div_rem  = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, m};
    div_fits = (div_rem >= {1'b0, m});

    if (div) begin
      if (div_fits) begin
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative 32-bit MULT/MULTU/DIV/DIVU with the result in HI/LO.
// Latency: 33 cycles from the start edge to done; start ignored while busy.
// Ports: clk, rst_n (async active-low), start/op/a/b request, busy, done
//        (1-cycle pulse), hi/lo result, div_by_zero (held until next done).
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  state_e             state;
  op_e                op_q;
  logic [5:0]         cnt;
  logic               neg_a;
  logic               neg_b;
  logic               b_zero;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;

  // Operand magnitudes; op[0] marks the signed variants. The magnitude of the
  // most negative value wraps to itself, which is correct read as unsigned.
  logic             in_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic             is_div;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  always_comb begin
    in_signed = op[0];
    a_mag     = (in_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (in_signed && b[WIDTH-1]) ? -b : b;
  end

  assign is_div = (op_q == OP_DIVU) || (op_q == OP_DIV);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div      (is_div),
    .acc      (acc),
    .m        (m),
    .acc_next (acc_next)
  );

  // Sign correction. For a zero divisor every trial subtract succeeds, so the
  // remainder ends up equal to the dividend magnitude; the dividend-sign fix
  // below then restores the original a, and only lo needs overriding.
  always_comb begin
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (is_div) begin
      if (neg_a ^ neg_b) fix_lo = -acc[WIDTH-1:0];
      if (neg_a)         fix_hi = -acc[2*WIDTH-1:WIDTH];
      if (b_zero)        fix_lo = '1;
    end else if (neg_a ^ neg_b) begin
      {fix_hi, fix_lo} = -acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= OP_MULTU;
      cnt         <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      b_zero      <= 1'b0;
      m           <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // busy stays up through the done cycle and drops with done here,
          // unless a back-to-back start is taken on this same edge.
          done <= 1'b0;
          cnt  <= '0;
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            op_q   <= op_e'(op);
            neg_a  <= in_signed && a[WIDTH-1];
            neg_b  <= in_signed && b[WIDTH-1];
            b_zero <= (b == '0);
            if (op[1]) begin
              m   <= b_mag;
              acc <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              m   <= a_mag;
              acc <= {{WIDTH{1'b0}}, b_mag};
            end
          end else begin
            busy <= 1'b0;
          end
        end

        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(MDU_ITERS - 1)) state <= FIX;
        end

        FIX: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          div_by_zero <= is_div && b_zero;
          done        <= 1'b1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter.
// A transaction-level reference model predicts every output each cycle.
// Directed cases pin literal results; a random phase covers the rest.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi, lo} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: res = {32'b0, x} * {32'b0, y};
      2'b01: begin p = sx * sy; res = p; end
      2'b10: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Cycle model: an accepted op completes 33 edges later; busy covers the
  // done cycle; a new start is accepted from the edge on which done falls.
  int          m_t = -1;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_dbz = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  logic        m_pend_dbz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = -1; m_busy = 0; m_done = 0; m_dbz = 0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      if (m_t >= 0) begin
        m_t++;
        if (m_t == 33) begin
          m_done = 1'b1;
          {m_hi, m_lo} = m_pend;
          m_dbz = m_pend_dbz;
        end else if (m_t == 34) begin
          m_t = -1;
        end
      end
      if (m_t == -1 && start) begin
        m_t = 0;
        m_pend = ref_result(op, a, b);
        m_pend_dbz = op[1] && (b == 0);
      end
      m_busy = (m_t >= 0);
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (cmp_en) begin
      chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
      chk("cyc_done", {31'b0, done}, {31'b0, m_done});
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
      chk("cyc_dbz", {31'b0, div_by_zero}, {31'b0, m_dbz});
    end
  end

  // Called at a negedge; start is sampled on the next rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_dir(input string name, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] e_hi,
                         input logic [31:0] e_lo, input logic e_dbz);
    int lat;
    issue(o, x, y);
    wait_done(lat);
    chk({name, "_lat"}, lat, 33);
    chk({name, "_hi"}, hi, e_hi);
    chk({name, "_lo"}, lo, e_lo);
    chk({name, "_dbz"}, {31'b0, div_by_zero}, {31'b0, e_dbz});
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int d0;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Directed results, issued back to back (start on the done cycle).
    d0 = done_cnt;
    run_dir("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_dir("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_dir("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    run_dir("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_dir("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_dir("divu_z", 2'b10, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1);
    run_dir("divu_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_dir("div_z_neg", 2'b11, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);
    #1;
    chk("b2b_dones", done_cnt - d0, 8);

    // start pulses while busy must be ignored.
    @(negedge clk);
    d0 = done_cnt;
    issue(2'b00, 32'd6, 32'd7);
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 5 || lat == 20) begin
        start = 1'b1; op = 2'b11; a = 32'd1234; b = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("busy_start_lat", lat, 33);
    chk("busy_start_hi", hi, 32'd0);
    chk("busy_start_lo", lo, 32'd42);
    repeat (40) @(negedge clk);
    #1;
    chk("busy_start_dones", done_cnt - d0, 1);

    // Asynchronous reset in the middle of a divide.
    issue(2'b10, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    @(negedge clk);
    run_dir("after_rst", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // Random operations with random idle gaps (gap 0 = back to back).
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ro = 2'($urandom);
      ra = rnd_operand();
      rb = rnd_operand();
      issue(ro, ra, rb);
      wait_done(lat);
      chk("rnd_lat", lat, 33);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
